green_gpio_ctrl: RTL and testbench

- Parametrised GPIO sideband controller for the green region. It replaces the fixed 5+5-bit tie-off/sample-only GPIO handling with a register-programmable block.
- Per-pin features: 2-FF input synchronisation, programmable debounce, sticky rise/fall edge capture, drive/output-enable registers, and a level interrupt.
- Sits on the Clk_100 domain between the board GPIO pins (b2g/g2b/oen) and a simple CSR port driven by the AFU MMIO decoder.

---
 rtl/green_gpio_pkg.sv | 24 ++
 rtl/gpio_debounce.sv | 78 +++++++
 rtl/green_gpio_ctrl.sv | 155 +++++++++++++++
 tb/tb_green_gpio_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/green_gpio_pkg.sv
// Shared definitions for the green-region GPIO sideband controller:
// CSR register indices, the identification constant and the address type.
package green_gpio_pkg;

  typedef logic [2:0] t_gpio_csr_addr;

  localparam t_gpio_csr_addr GPIO_OUT    = 3'd0;
  localparam t_gpio_csr_addr GPIO_OEN    = 3'd1;
  localparam t_gpio_csr_addr GPIO_IN     = 3'd2;
  localparam t_gpio_csr_addr GPIO_RISE   = 3'd3;
  localparam t_gpio_csr_addr GPIO_FALL   = 3'd4;
  localparam t_gpio_csr_addr GPIO_IRQ_EN = 3'd5;
  localparam t_gpio_csr_addr GPIO_DBNC   = 3'd6;
  localparam t_gpio_csr_addr GPIO_ID_IDX = 3'd7;

  // ASCII "GPI" in the upper three bytes of the ID register.
  localparam logic [23:0] GPIO_ID = 24'h47_50_49;

  // ID register word: identification constant with the pin count in [7:0].
  function automatic logic [31:0] gpio_id_word(input int num_gpio);
    return {GPIO_ID, 8'(num_gpio)};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input path: 2-FF synchroniser, debounce counter, qualified
// stable level and one-cycle rise/fall pulses aligned with the edge on
// which the stable level changes.
module gpio_debounce
  import green_gpio_pkg::*;
#(
  parameter int DBNC_W = 16
) (
  input  logic              Clk_100,
  input  logic              SoftReset_n,
  input  logic              din,
  input  logic [DBNC_W-1:0] limit,
  output logic              stable,
  output logic              rise,
  output logic              fall
);

  localparam logic [DBNC_W-1:0] ONE = DBNC_W'(1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic [DBNC_W-1:0] r_cnt;

  logic              w_bypass;
  logic              w_differ;
  logic              w_expire;
  logic              w_stable_nxt;
  logic [DBNC_W-1:0] w_cnt_nxt;

  assign w_bypass = (limit == '0);
  assign w_differ = (r_sync2 != r_stable);
  // ">=" rather than "==" so that lowering the limit below the running
  // count still qualifies the level on the very next edge.
  assign w_expire = (r_cnt >= (limit - ONE));

  // Next stable level and counter value from the current sample.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    if (w_bypass) begin
      w_stable_nxt = r_sync2;
    end else if (w_differ) begin
      if (w_expire) begin
        w_stable_nxt = r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end
  end

  // Two-flop synchroniser on the raw asynchronous pin.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter and qualified level.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign stable = r_stable;
  assign rise   = w_stable_nxt & ~r_stable;
  assign fall   = ~w_stable_nxt & r_stable;

endmodule

// File: rtl/green_gpio_ctrl.sv
// Register-programmable GPIO sideband controller on Clk_100: per-pin
// debounce, sticky edge flags, drive/output-enable registers and a level
// interrupt, accessed through a strobe-based CSR port.
//
// CSR port: csr_wr and csr_rd are single-cycle strobes with no back-pressure.
// A write lands on the edge where csr_wr is high. A read samples the register
// on the edge where csr_rd is high (before any same-edge write) and presents
// it on csr_rdata with csr_rvalid high for exactly one cycle afterwards;
// csr_rdata is 0 whenever csr_rvalid is 0.
module green_gpio_ctrl
  import green_gpio_pkg::*;
#(
  parameter int                NUM_GPIO = 10,
  parameter int                DBNC_W   = 16,
  parameter logic [DBNC_W-1:0] DBNC_RST = DBNC_W'(1000)
) (
  input  logic                Clk_100,
  input  logic                SoftReset_n,
  input  logic [NUM_GPIO-1:0] b2g_gpio,
  output logic [NUM_GPIO-1:0] g2b_gpio,
  output logic [NUM_GPIO-1:0] oen_gpio,
  input  logic                csr_wr,
  input  logic                csr_rd,
  input  t_gpio_csr_addr      csr_addr,
  input  logic [31:0]         csr_wdata,
  output logic [31:0]         csr_rdata,
  output logic                csr_rvalid,
  output logic                irq
);

  logic [NUM_GPIO-1:0] r_out;
  logic [NUM_GPIO-1:0] r_oen;
  logic [NUM_GPIO-1:0] r_rise;
  logic [NUM_GPIO-1:0] r_fall;
  logic [NUM_GPIO-1:0] r_irq_en;
  logic [DBNC_W-1:0]   r_dbnc;
  logic                r_irq;
  logic                r_rvalid;
  logic [31:0]         r_rdata;

  logic [NUM_GPIO-1:0] w_stable;
  logic [NUM_GPIO-1:0] w_rise;
  logic [NUM_GPIO-1:0] w_fall;
  logic [NUM_GPIO-1:0] w_wdata_n;
  logic [DBNC_W-1:0]   w_wdata_d;
  logic [NUM_GPIO-1:0] w_rise_clr;
  logic [NUM_GPIO-1:0] w_fall_clr;
  logic                w_wr_out;
  logic                w_wr_oen;
  logic                w_wr_rise;
  logic                w_wr_fall;
  logic                w_wr_irq_en;
  logic                w_wr_dbnc;
  logic [31:0]         w_rd_mux;
  logic                w_unused_wdata;

  // Bits above the pin count (or the debounce width) are dropped on write.
  assign w_wdata_n      = csr_wdata[NUM_GPIO-1:0];
  assign w_wdata_d      = csr_wdata[DBNC_W-1:0];
  assign w_unused_wdata = ^csr_wdata;

  assign w_wr_out    = csr_wr && (csr_addr == GPIO_OUT);
  assign w_wr_oen    = csr_wr && (csr_addr == GPIO_OEN);
  assign w_wr_rise   = csr_wr && (csr_addr == GPIO_RISE);
  assign w_wr_fall   = csr_wr && (csr_addr == GPIO_FALL);
  assign w_wr_irq_en = csr_wr && (csr_addr == GPIO_IRQ_EN);
  assign w_wr_dbnc   = csr_wr && (csr_addr == GPIO_DBNC);

  assign w_rise_clr = w_wr_rise ? w_wdata_n : '0;
  assign w_fall_clr = w_wr_fall ? w_wdata_n : '0;

  // One debounce channel per pin, all sharing the programmed limit.
  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
    gpio_debounce #(
      .DBNC_W (DBNC_W)
    ) u_dbnc (
      .Clk_100     (Clk_100),
      .SoftReset_n (SoftReset_n),
      .din         (b2g_gpio[g]),
      .limit       (r_dbnc),
      .stable      (w_stable[g]),
      .rise        (w_rise[g]),
      .fall        (w_fall[g])
    );
  end

  // Read-data selection; narrow registers are zero-extended.
  always_comb begin
    w_rd_mux = '0;
    case (csr_addr)
      GPIO_OUT:    w_rd_mux = 32'(r_out);
      GPIO_OEN:    w_rd_mux = 32'(r_oen);
      GPIO_IN:     w_rd_mux = 32'(w_stable);
      GPIO_RISE:   w_rd_mux = 32'(r_rise);
      GPIO_FALL:   w_rd_mux = 32'(r_fall);
      GPIO_IRQ_EN: w_rd_mux = 32'(r_irq_en);
      GPIO_DBNC:   w_rd_mux = 32'(r_dbnc);
      GPIO_ID_IDX: w_rd_mux = gpio_id_word(NUM_GPIO);
      default:     w_rd_mux = '0;
    endcase
  end

  // Plain read/write control registers.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_out    <= '0;
      r_oen    <= '0;
      r_irq_en <= '0;
      r_dbnc   <= DBNC_RST;
    end else begin
      if (w_wr_out)    r_out    <= w_wdata_n;
      if (w_wr_oen)    r_oen    <= w_wdata_n;
      if (w_wr_irq_en) r_irq_en <= w_wdata_n;
      if (w_wr_dbnc)   r_dbnc   <= w_wdata_d;
    end
  end

  // Sticky edge flags: write-one-to-clear, a new edge in the same cycle wins.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= (r_rise & ~w_rise_clr) | w_rise;
      r_fall <= (r_fall & ~w_fall_clr) | w_fall;
    end
  end

  // Level interrupt, registered from the current flag state.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((r_rise | r_fall) & r_irq_en);
    end
  end

  // Read response: one-cycle valid pulse, data forced to 0 when idle.
  always_ff @(posedge Clk_100 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= csr_rd;
      r_rdata  <= csr_rd ? w_rd_mux : '0;
    end
  end

  assign g2b_gpio   = r_out;
  assign oen_gpio   = r_oen;
  assign irq        = r_irq;
  assign csr_rvalid = r_rvalid;
  assign csr_rdata  = r_rdata;

endmodule

// File: tb/tb_green_gpio_ctrl.sv
// Bench for green_gpio_ctrl: directed scenarios followed by random pin and
// CSR traffic, every cycle compared against a behavioural reference model.
module tb_green_gpio_ctrl;

  localparam int N  = 10;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          Clk_100 = 1'b0;
  logic          SoftReset_n;
  logic [N-1:0]  b2g_gpio;
  logic [N-1:0]  g2b_gpio;
  logic [N-1:0]  oen_gpio;
  logic          csr_wr;
  logic          csr_rd;
  logic [2:0]    csr_addr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid;
  logic          irq;

  always #5 Clk_100 = ~Clk_100;

  green_gpio_ctrl #(
    .NUM_GPIO (N),
    .DBNC_W   (DW),
    .DBNC_RST (16'd1000)
  ) dut (
    .Clk_100     (Clk_100),
    .SoftReset_n (SoftReset_n),
    .b2g_gpio    (b2g_gpio),
    .g2b_gpio    (g2b_gpio),
    .oen_gpio    (oen_gpio),
    .csr_wr      (csr_wr),
    .csr_rd      (csr_rd),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_rvalid  (csr_rvalid),
    .irq         (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Pin history, one word per clock edge since reset. The synchronised value
  // seen at an edge is the pin two edges earlier. A pin's qualified level
  // flips when the last DBNC synchronised samples all disagree with it.
  logic [N-1:0]  hist[$];
  logic [31:0]   exp_q[$];
  logic [N-1:0]  m_out, m_oen, m_stable, m_rise, m_fall, m_ien;
  logic [31:0]   m_dbnc;
  logic          m_irq, m_rv;

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_out = '0; m_oen = '0; m_stable = '0; m_rise = '0; m_fall = '0;
    m_ien = '0; m_dbnc = 32'd1000; m_irq = 1'b0; m_rv = 1'b0;
  endtask

  function automatic logic sync_at(input int pin, input int back);
    int idx;
    logic [N-1:0] w;
    idx = hist.size() - 3 - back;
    if (idx < 0) return 1'b0;
    w = hist[idx];
    return w[pin];
  endfunction

  function automatic logic settle(input int pin);
    if (m_dbnc == 0) return sync_at(pin, 0);
    for (int j = 0; j < int'(m_dbnc); j++)
      if (sync_at(pin, j) == m_stable[pin]) return m_stable[pin];
    return ~m_stable[pin];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_out);
      3'd1: return 32'(m_oen);
      3'd2: return 32'(m_stable);
      3'd3: return 32'(m_rise);
      3'd4: return 32'(m_fall);
      3'd5: return 32'(m_ien);
      3'd6: return m_dbnc;
      default: return {24'h475049, 8'(N)};
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_edge();
    logic [N-1:0] snew, rp, fp, wd;
    logic irq_n;
    m_rv = csr_rd;
    if (csr_rd) exp_q.push_back(model_read(csr_addr));
    irq_n = |((m_rise | m_fall) & m_ien);
    hist.push_back(b2g_gpio);
    for (int i = 0; i < N; i++) snew[i] = settle(i);
    rp = snew & ~m_stable;
    fp = ~snew & m_stable;
    m_stable = snew;
    wd = csr_wdata[N-1:0];
    if (csr_wr) begin
      case (csr_addr)
        3'd0: m_out = wd;
        3'd1: m_oen = wd;
        3'd3: m_rise = m_rise & ~wd;
        3'd4: m_fall = m_fall & ~wd;
        3'd5: m_ien = wd;
        3'd6: m_dbnc = csr_wdata & 32'h0000_FFFF;
        default: ;
      endcase
    end
    m_rise = m_rise | rp;
    m_fall = m_fall | fp;
    m_irq  = irq_n;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e;
    chk("rvalid", 32'(csr_rvalid), 32'(m_rv));
    if (m_rv) begin
      e = exp_q.pop_front();
      chk("rdata", csr_rdata, e);
    end else begin
      chk("rdata_idle", csr_rdata, 32'h0);
    end
    chk("g2b_gpio", 32'(g2b_gpio), 32'(m_out));
    chk("oen_gpio", 32'(oen_gpio), 32'(m_oen));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic step();
    @(posedge Clk_100);
    model_edge();
    @(negedge Clk_100);
    check_outputs();
    csr_wr = 1'b0;
    csr_rd = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    step();
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
    csr_rd = 1'b1; csr_addr = a;
    step();
    chk(tag, csr_rdata, exp);
  endtask

  task automatic do_reset(input int hold);
    SoftReset_n = 1'b0;
    #1;
    chk("rst_g2b", 32'(g2b_gpio), 32'h0);
    chk("rst_oen", 32'(oen_gpio), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(csr_rvalid), 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    repeat (hold) @(negedge Clk_100);
    model_reset();
    SoftReset_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  ra, wa;
    logic [31:0] exp_id;
    int          op;

    SoftReset_n = 1'b1;
    b2g_gpio = '0; csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = '0; csr_wdata = '0;
    model_reset();
    #1;
    do_reset(3);

    // Reset defaults.
    exp_id = 32'h4750_490A;
    for (int a = 0; a < 6; a++) read_expect("rst_reg", 3'(a), 32'h0);
    read_expect("rst_dbnc", 3'd6, 32'h0000_03E8);
    read_expect("id", 3'd7, exp_id);

    // Pin drive.
    csr_write(3'd0, 32'hFFFF_F2A5);
    chk("drive_out", 32'(g2b_gpio), 32'h2A5);
    csr_write(3'd1, 32'h0000_03FF);
    chk("drive_oen", 32'(oen_gpio), 32'h3FF);
    read_expect("readback_out", 3'd0, 32'h2A5);

    // Debounce with limit 4: a 3-cycle pulse is rejected.
    csr_write(3'd6, 32'h0000_0004);
    b2g_gpio[0] = 1'b1;
    repeat (3) step();
    b2g_gpio[0] = 1'b0;
    for (int k = 0; k < 8; k++) read_expect("glitch_in", 3'd2, 32'h0);
    read_expect("glitch_rise", 3'd3, 32'h0);

    // A held level qualifies 2 + 4 edges after the pin changes; a read on
    // edge k reports the level after edge k-1.
    b2g_gpio[0] = 1'b1;
    for (int k = 1; k <= 10; k++) read_expect("qual_in", 3'd2, (k >= 7) ? 32'h1 : 32'h0);
    read_expect("qual_rise", 3'd3, 32'h1);

    // Interrupt on a falling edge of pin 0.
    csr_write(3'd3, 32'h1);
    csr_write(3'd5, 32'h1);
    b2g_gpio[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("irq_rise_time", 32'(irq), (k == 7) ? 32'h1 : 32'h0);
    end
    read_expect("irq_fall_flag", 3'd4, 32'h1);
    csr_write(3'd4, 32'h1);
    chk("irq_hold", 32'(irq), 32'h1);
    step();
    chk("irq_clear", 32'(irq), 32'h0);

    // W1C landing on the same edge as a new rising edge (bypass mode).
    csr_write(3'd6, 32'h0);
    b2g_gpio[3] = 1'b1;
    step();
    step();
    csr_write(3'd3, 32'h8);
    read_expect("w1c_collide", 3'd3, 32'h8);
    csr_write(3'd3, 32'h8);
    read_expect("w1c_clear", 3'd3, 32'h0);

    // Random pin and CSR traffic at several debounce limits.
    for (int r = 0; r < 4; r++) begin
      csr_write(3'd6, 32'($urandom_range(0, 5)));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 3) == 0) b2g_gpio[$urandom_range(0, N-1)] ^= 1'b1;
        op = $urandom_range(0, 3);
        ra = 3'($urandom_range(0, 7));
        wa = 3'($urandom_range(0, 7));
        if (wa == 3'd6) wa = 3'd5;
        if (op == 1 || op == 3) begin csr_rd = 1'b1; csr_addr = ra; end
        if (op == 2 || op == 3) begin csr_wr = 1'b1; csr_addr = wa; csr_wdata = $urandom; end
        // Both strobes: the read uses the write's address half the time.
        if (op == 3 && $urandom_range(0, 1) == 1) csr_addr = wa;
        step();
      end
    end

    // Same-cycle write and read of one register returns the old value.
    csr_write(3'd5, 32'h0);
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 3'd5; csr_wdata = 32'h155;
    step();
    chk("wr_rd_same", csr_rdata, 32'h0);
    read_expect("wr_rd_after", 3'd5, 32'h155);

    // Reset in the middle of a long debounce count.
    b2g_gpio = '0;
    csr_write(3'd6, 32'h2);
    repeat (20) step();
    csr_write(3'd6, 32'd100);
    b2g_gpio[1] = 1'b1;
    repeat (52) step();
    do_reset(2);
    csr_write(3'd6, 32'd100);
    read_expect("rst_mid_rise", 3'd3, 32'h0);
    read_expect("rst_mid_dbnc", 3'd6, 32'd100);
    repeat (98) step();
    read_expect("rst_mid_in_101", 3'd2, 32'h0);
    read_expect("rst_mid_in_102", 3'd2, 32'h2);
    read_expect("rst_mid_rise_set", 3'd3, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
